// File: rtl/s2p_deser.sv
// Serial-to-parallel deserializer: LSB-first 1-bit stream into N-bit words, buffered in a DEPTH-entry FIFO.
// Latency: the word's final accepted bit at edge k makes it visible on par_data/par_valid right after edge k.
// Backpressure: serial bits 0..N-2 always accepted; the final bit is held off only while the FIFO is full (registered decision).
module s2p_deser #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clr,
  input  logic                         ser_data,
  input  logic                         ser_valid,
  output logic                         ser_ready,
  output logic [N-1:0]                 par_data,
  output logic                         par_valid,
  input  logic                         par_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         busy
);

  localparam int CW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  shreg;
  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          last_bit;
  logic          bit_acc;
  logic          push;
  logic          pop;
  logic [N-1:0]  word_nxt;

  // The final bit of a word is only refused when there is no room to push it;
  // using registered level keeps par_ready out of the ser_ready path.
  assign last_bit  = (bit_cnt == CW'(N-1));
  assign ser_ready = !((level == LW'(DEPTH)) && last_bit);
  assign bit_acc   = ser_valid && ser_ready;
  assign push      = bit_acc && last_bit;
  assign par_valid = (level != '0);
  assign pop       = par_valid && par_ready;
  assign word_nxt  = {ser_data, shreg[N-1:1]};
  assign par_data  = mem[rd_ptr];
  assign busy      = (bit_cnt != '0);

  // Shift in accepted bits and track position within the current word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (bit_acc) begin
      shreg   <= word_nxt;
      bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
    end
  end

  // Word FIFO: write completed words, advance read side on consumer handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word_nxt;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

endmodule

// File: tb/tb_s2p_deser.sv
// Randomized bench for s2p_deser against a word-queue reference model.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// Each step checks all outputs, then drives inputs and advances the model by one rising edge.
module tb_s2p_deser;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rstn;
  logic          clr;
  logic          ser_data;
  logic          ser_valid;
  logic          ser_ready;
  logic [N-1:0]  par_data;
  logic          par_valid;
  logic          par_ready;
  logic [LW-1:0] level;
  logic          busy;

  s2p_deser #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .clr(clr),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .par_data(par_data), .par_valid(par_valid), .par_ready(par_ready),
    .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: queue of completed words plus the partially received word.
  logic [N-1:0] q[$];
  logic [N-1:0] rx[$];
  int           bits;
  logic [N-1:0] cur;
  logic         last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready();
    return !(q.size() == DEPTH && bits == N-1);
  endfunction

  task automatic model_reset();
    q.delete();
    bits = 0;
    cur  = '0;
  endtask

  task automatic check_outputs();
    chk("ser_ready", 32'(ser_ready), 32'(exp_ready()));
    chk("par_valid", 32'(par_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("par_data", 32'(par_data), 32'(q[0]));
    chk("level", 32'(level), 32'(q.size()));
    chk("busy", 32'(busy), 32'(bits != 0));
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic step(input logic sv, input logic sd, input logic pr, input logic cl);
    logic acc, pp;
    check_outputs();
    ser_valid = sv;
    ser_data  = sd;
    par_ready = pr;
    clr       = cl;
    acc = sv && exp_ready();
    pp  = (q.size() != 0) && pr;
    last_acc = acc && !cl;
    if (cl) begin
      model_reset();
    end else begin
      if (pp) begin
        rx.push_back(par_data);
        void'(q.pop_front());
      end
      if (acc) begin
        cur[bits] = sd;
        bits++;
        if (bits == N) begin
          q.push_back(cur);
          bits = 0;
          cur  = '0;
        end
      end
    end
    @(negedge clk);
    ser_valid = 1'b0;
    clr       = 1'b0;
  endtask

  // Send bits [0 .. nbits-1] of w, with 0..maxgap idle cycles before each bit.
  task automatic send_bits(input logic [N-1:0] w, input int nbits, input int maxgap, input logic pr);
    for (int i = 0; i < nbits; i++) begin
      int gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      int tries = 0;
      for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), pr, 1'b0);
      do begin
        step(1'b1, w[i], pr, 1'b0);
        tries++;
      end while (!last_acc && tries < 40);
      if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 40) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      t++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; ser_data = 1'b1; ser_valid = 1'b1; par_ready = 1'b0;
    model_reset();
    @(negedge clk);
    ser_valid = 1'b0;
    check_outputs();
    chk("rst_par_data", 32'(par_data), 32'd0);
    rstn = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // 1: single word, consumer always ready
    send_bits(8'hA5, N, 0, 1'b1);
    chk("t1_vld", 32'(par_valid), 32'd1);
    chk("t1_data", 32'(par_data), 32'hA5);
    chk("t1_level", 32'(level), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_vld_off", 32'(par_valid), 32'd0);
    chk("t1_level0", 32'(level), 32'd0);

    // 2: fill FIFO, stall final bit, then drain in order
    rx.delete();
    for (int w = 1; w <= 4; w++) send_bits(N'(w), N, 0, 1'b0);
    send_bits(8'h05, N-1, 0, 1'b0);
    chk("t2_level4", 32'(level), 32'd4);
    chk("t2_stall", 32'(ser_ready), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_refused", 32'(last_acc), 32'd0);
    chk("t2_level3", 32'(level), 32'd3);
    chk("t2_ready_back", 32'(ser_ready), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2_last_acc", 32'(last_acc), 32'd1);
    drain();
    chk("t2_rx_cnt", 32'(rx.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx.size(); i++) chk("t2_order", 32'(rx[i]), 32'(i+1));

    // 3: random gaps between bits
    rx.delete();
    send_bits(8'h3C, N, 5, 1'b1);
    send_bits(8'hFF, N, 5, 1'b1);
    send_bits(8'h00, N, 5, 1'b1);
    drain();
    chk("t3_rx_cnt", 32'(rx.size()), 32'd3);
    if (rx.size() == 3) begin
      chk("t3_w0", 32'(rx[0]), 32'h3C);
      chk("t3_w1", 32'(rx[1]), 32'hFF);
      chk("t3_w2", 32'(rx[2]), 32'h00);
    end

    // 4: flush with queued words and a partial word
    send_bits(8'h11, N, 0, 1'b0);
    send_bits(8'h22, N, 0, 1'b0);
    send_bits(8'h33, 3, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_level", 32'(level), 32'd0);
    chk("t4_vld", 32'(par_valid), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ready", 32'(ser_ready), 32'd1);
    rx.delete();
    send_bits(8'h5A, N, 0, 1'b1);
    drain();
    chk("t4_rx_cnt", 32'(rx.size()), 32'd1);
    if (rx.size() == 1) chk("t4_word", 32'(rx[0]), 32'h5A);

    // 5: push and pop on the same edge at level 2
    send_bits(8'hC1, N, 0, 1'b0);
    send_bits(8'hC2, N, 0, 1'b0);
    send_bits(8'hC3, N-1, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t5_level", 32'(level), 32'd2);
    chk("t5_head", 32'(par_data), 32'hC2);
    drain();

    // 6: asynchronous reset mid-word with words queued
    send_bits(8'h0A, N, 0, 1'b0);
    send_bits(8'h0B, N, 0, 1'b0);
    send_bits(8'h0C, N, 0, 1'b0);
    send_bits(8'hF0, 4, 0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    chk("t6_ready", 32'(ser_ready), 32'd1);
    chk("t6_vld", 32'(par_valid), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    rx.delete();
    send_bits(8'h81, N, 0, 1'b1);
    drain();
    chk("t6_rx_cnt", 32'(rx.size()), 32'd1);
    if (rx.size() == 1) chk("t6_word", 32'(rx[0]), 32'h81);

    // Random soak: valid, data, ready and occasional flush all randomized
    for (int c = 0; c < 600; c++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 59) == 0));
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
